n8_poll_scheduler: RTL and testbench
====================================

Name: n8_poll_scheduler

Overview:
Fully synchronous sequencer for the N8 controller serial bus. Drives one shared latch/pulse pair to NUM_PADS pads, shifts every pad's data line in parallel, and publishes a committed button word per pad with a one-cycle valid strobe. Polls start on request from game logic or from an internal auto-poll timer; one request can be queued while busy. Sits between the N8 pad pins and the PacMan input/FSM logic.

Parameters:
BITS, 8, buttons per pad (>=2)
NUM_PADS, 2, pads sharing latch/pulse, each with its own data line
TICK_DIV, 5000, clk cycles per bus phase tick (>=2)
GAP_TICKS, 10, cooldown ticks after commit before the next poll may start
AUTO_PERIOD, 0, clk cycles between automatic poll triggers; 0 disables auto-poll

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
poll_req  in  1  single-cycle poll request
data_in  in  NUM_PADS  serial data, one bit per pad, sampled synchronously
latch  out  1  N8 latch line (registered)
pulse  out  1  N8 clock/pulse line (registered)
busy  out  1  high from poll start until end of GAP
buttons  out  NUM_PADS*BITS  committed words; pad p occupies [p*BITS +: BITS]
valid  out  1  one-cycle strobe when buttons updates
pressed  out  NUM_PADS*BITS  newly pressed bits, qualified by valid

Behaviour:
- Reset (synchronous): latch=0, pulse=0, busy=0, valid=0, buttons=0, pressed=0, shift regs=0, pending=0, tick counter=0, auto counter=0, state=IDLE. Reset mid-poll aborts on the next edge; no partial commit.
- Tick: tick counter restarts at 0 on entry to LATCH; one tick = TICK_DIV clk cycles. All phase lengths below are in ticks.
- Trigger = poll_req OR (AUTO_PERIOD>0 AND auto counter reaches AUTO_PERIOD-1; counter then wraps to 0, free-running).
- States:
  IDLE: latch=0, pulse=0, busy=0. On trigger or pending -> LATCH next cycle; pending cleared.
  LATCH: latch=1 for 2 ticks. On last clk cycle, sample data_in into shift regs -> LOW.
  LOW: both lines 0 for 1 tick. If bits sampled == BITS -> COMMIT, else -> PULSE.
  PULSE: pulse=1 for 1 tick. On last clk cycle, sample data_in -> LOW.
  COMMIT: 1 cycle; buttons <= shift regs, valid=1 -> GAP.
  GAP: lines 0 for GAP_TICKS ticks, busy=1 -> IDLE.
- Sampling: exactly BITS samples per pad per poll (1 at latch fall, BITS-1 at pulse falls), taken coincident with the falling edge. Shift left, new bit into LSB: first sample ends in bit BITS-1, last in bit 0. No inversion; raw line levels stored.
- Poll length: 2 + 1 + 2*(BITS-1) ticks plus 1 COMMIT cycle; BITS=8 -> 17 ticks + 1 clk.
- latch and pulse never high simultaneously; each phase is exactly N*TICK_DIV cycles.
- Triggers while busy (any non-IDLE state, COMMIT included) set pending (1-deep; extras dropped). A trigger in IDLE starts a poll directly. Pending in IDLE starts next poll on the next cycle.
- buttons holds its value between commits; valid is never high two consecutive cycles.

Optional Feature:
N8_PRESS_EDGE_EN: when defined, COMMIT also registers pressed <= new & ~old per bit (old = buttons before commit); pressed holds until the next commit. When undefined, pressed is constant 0 and no previous-word compare logic exists. All other behaviour is identical.

Decomposition:
- Package n8_pkg: state enum n8_state_t {IDLE, LATCH, LOW, PULSE, COMMIT, GAP}; localparams LATCH_TICKS=2, PULSE_TICKS=1, LOW_TICKS=1.
- One sub-module: n8_tick_gen (TICK_DIV divider with synchronous restart, emits last-cycle-of-tick strobe), which also replaces the ripple-derived clock in the existing serial driver.

Test Plan:
- Bench params BITS=8, NUM_PADS=2, TICK_DIV=4, GAP_TICKS=2, AUTO_PERIOD=0. poll_req 1 cycle, pad0 model serial 8'hA5, pad1 8'h3C -> latch high 8 cycles, 7 pulses of 4 cycles each, valid exactly 69 cycles after poll start, buttons=16'h3CA5.
- Reset asserted during 4th pulse -> next cycle latch=0, pulse=0, buttons=0, busy=0; valid never fires for the aborted poll.
- Three poll_req during one poll -> exactly one follow-on poll, starting the cycle after GAP ends; total valid count 2.
- AUTO_PERIOD=200, no poll_req, 1000 cycles -> polls start at cycles 199, 399, 599, 799, 999 (5 valid strobes, one per triggered poll).
- With N8_PRESS_EDGE_EN: pad0 8'h01 then 8'h03 -> second commit pressed[7:0]=8'h02; without macro, pressed stays 0.
- Continuous checker: latch & pulse never both 1; valid width 1; sample count per poll = 8.

Source files
------------

// File: rtl/n8_poll_scheduler_pkg.sv
// N8 poll scheduler shared types: FSM state encoding and fixed phase lengths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package n8_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    PULSE,
    COMMIT,
    GAP
  } n8_state_t;

  // Bus phase lengths in ticks.
  localparam int LATCH_TICKS = 2;
  localparam int PULSE_TICKS = 1;
  localparam int LOW_TICKS   = 1;

  // Width of the per-phase tick counter; wide enough for any practical GAP_TICKS.
  localparam int PH_W = 16;

endpackage

// File: rtl/n8_poll_scheduler_tick_gen.sv
// Bus phase tick divider: counts TICK_DIV clk cycles per tick, restartable.
// Latency: tick_last is high on the last cycle of each tick; restart zeroes the count on the next edge.
// Backpressure: none, free-running clock-enable style divider (no derived clocks).
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   restart     - forces the divider back to count 0 on the next edge
//   tick_last   - high during the final clk cycle of the current tick
module n8_tick_gen #(
  parameter int TICK_DIV = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick_last
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick_last = (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_q <= '0;
    end else if (tick_last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/n8_poll_scheduler.sv
// N8 controller bus sequencer: latch/pulse generation, parallel pad shift-in, committed button words.
// Latency: valid rises 1 + 17 ticks after a trigger in IDLE (BITS=8); outputs are registered.
// Backpressure: none; triggers while busy queue a single pending poll, further ones are dropped.
//
// Ports:
//   clk, reset        - system clock, synchronous active-high reset (aborts a poll, nothing committed)
//   poll_req          - single-cycle poll request
//   data_in[NUM_PADS] - serial data, one line per pad
//   latch, pulse      - shared N8 bus lines (registered, never high together)
//   busy              - high from LATCH through the end of GAP
//   buttons           - committed words, pad p at [p*BITS +: BITS]
//   valid             - one-cycle strobe coincident with a buttons update
//   pressed           - newly pressed bits per commit; compiled in only with N8_PRESS_EDGE_EN,
//                       otherwise tied to zero
module n8_poll_scheduler
  import n8_pkg::*;
#(
  parameter int BITS        = 8,
  parameter int NUM_PADS    = 2,
  parameter int TICK_DIV    = 5000,
  parameter int GAP_TICKS   = 10,
  parameter int AUTO_PERIOD = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     poll_req,
  input  logic [NUM_PADS-1:0]      data_in,
  output logic                     latch,
  output logic                     pulse,
  output logic                     busy,
  output logic [NUM_PADS*BITS-1:0] buttons,
  output logic                     valid,
  output logic [NUM_PADS*BITS-1:0] pressed
);

  localparam int W   = NUM_PADS * BITS;
  localparam int BCW = $clog2(BITS + 1);

  n8_state_t state_q, state_d;

  logic            tick_last;
  logic            restart;
  logic [PH_W-1:0] ph_cnt_q;
  logic [PH_W-1:0] ph_last;
  logic            phase_done;
  logic            sample;
  logic [BCW-1:0]  bit_cnt_q;
  logic            pending_q;
  logic            auto_hit;
  logic            trigger;

  logic            latch_q, pulse_q, busy_q, valid_q;
  logic            latch_d, pulse_d, busy_d, valid_d;
  logic [W-1:0]    buttons_q;
  logic [BITS-1:0] sr_q [NUM_PADS];
  logic [W-1:0]    sr_flat;

  // Every phase starts on a fresh tick so phase lengths are exact multiples of TICK_DIV,
  // including GAP, which follows the single-cycle COMMIT.
  assign restart = (state_d != state_q);

  n8_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .tick_last(tick_last)
  );

  // Free-running auto-poll timer, independent of the FSM.
  generate
    if (AUTO_PERIOD > 0) begin : g_auto
      localparam int AW = $clog2(AUTO_PERIOD) + 1;
      logic [AW-1:0] auto_cnt_q;

      assign auto_hit = (auto_cnt_q == AW'(AUTO_PERIOD - 1));

      always_ff @(posedge clk) begin
        if (reset || auto_hit) begin
          auto_cnt_q <= '0;
        end else begin
          auto_cnt_q <= auto_cnt_q + AW'(1);
        end
      end
    end else begin : g_no_auto
      assign auto_hit = 1'b0;
    end
  endgenerate

  assign trigger = poll_req || auto_hit;

  // Last tick index of the current phase.
  always_comb begin
    ph_last = '0;
    case (state_q)
      LATCH:   ph_last = PH_W'(LATCH_TICKS - 1);
      LOW:     ph_last = PH_W'(LOW_TICKS - 1);
      PULSE:   ph_last = PH_W'(PULSE_TICKS - 1);
      GAP:     ph_last = PH_W'(GAP_TICKS - 1);
      default: ph_last = '0;
    endcase
  end

  assign phase_done = tick_last && (ph_cnt_q == ph_last);

  // Samples land on the last cycle of LATCH/PULSE, i.e. together with the line's falling edge.
  assign sample = phase_done && ((state_q == LATCH) || (state_q == PULSE));

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger || pending_q) state_d = LATCH;
      LATCH:   if (phase_done) state_d = LOW;
      LOW:     if (phase_done) state_d = (bit_cnt_q == BCW'(BITS)) ? COMMIT : PULSE;
      PULSE:   if (phase_done) state_d = LOW;
      COMMIT:  state_d = (GAP_TICKS > 0) ? GAP : IDLE;
      GAP:     if (phase_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    latch_d = (state_d == LATCH);
    pulse_d = (state_d == PULSE);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == COMMIT);
  end

  always_comb begin
    sr_flat = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      sr_flat[p*BITS +: BITS] = sr_q[p];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ph_cnt_q  <= '0;
      bit_cnt_q <= '0;
      pending_q <= 1'b0;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      buttons_q <= '0;
      for (int p = 0; p < NUM_PADS; p++) begin
        sr_q[p] <= '0;
      end
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;

      if (restart) begin
        ph_cnt_q <= '0;
      end else if (tick_last) begin
        ph_cnt_q <= ph_cnt_q + PH_W'(1);
      end

      if (state_q == IDLE) begin
        bit_cnt_q <= '0;
      end else if (sample) begin
        bit_cnt_q <= bit_cnt_q + BCW'(1);
      end

      // First sample shifts all the way up to bit BITS-1.
      if (sample) begin
        for (int p = 0; p < NUM_PADS; p++) begin
          sr_q[p] <= {sr_q[p][BITS-2:0], data_in[p]};
        end
      end

      // IDLE always consumes pending (or starts directly), so only busy states can set it.
      if (state_q == IDLE) begin
        pending_q <= 1'b0;
      end else if (trigger) begin
        pending_q <= 1'b1;
      end

      // Load on entry to COMMIT so buttons is already updated while valid is high.
      if (state_d == COMMIT) begin
        buttons_q <= sr_flat;
      end
    end
  end

`ifdef N8_PRESS_EDGE_EN
  logic [W-1:0] pressed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pressed_q <= '0;
    end else if (state_d == COMMIT) begin
      pressed_q <= sr_flat & ~buttons_q;
    end
  end

  assign pressed = pressed_q;
`else
  assign pressed = '0;
`endif

  assign latch   = latch_q;
  assign pulse   = pulse_q;
  assign busy    = busy_q;
  assign valid   = valid_q;
  assign buttons = buttons_q;

endmodule

// File: tb/tb_n8_poll_scheduler.sv
// Self-checking bench for n8_poll_scheduler: table-driven polls with a scoreboard, reset abort,
// pending-request queueing, auto-poll schedule, and continuous bus-protocol monitors.
// Expected pressed values follow N8_PRESS_EDGE_EN when the bench is built with it.
module tb_n8_poll_scheduler;

  localparam int BITS      = 8;
  localparam int NUM_PADS  = 2;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 2;
  localparam int W         = BITS * NUM_PADS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, rst_auto, poll_req;
  logic [1:0]    data_in;
  logic          latch, pulse, busy, valid;
  logic [W-1:0]  buttons, pressed;

  logic [1:0]    a_data = 2'b11;
  logic          a_poll_req = 1'b0;
  logic          a_latch, a_pulse, a_busy, a_valid;
  logic [W-1:0]  a_buttons, a_pressed;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  n8_poll_scheduler #(
    .BITS(BITS), .NUM_PADS(NUM_PADS), .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS), .AUTO_PERIOD(0)
  ) dut (
    .clk(clk), .reset(reset), .poll_req(poll_req), .data_in(data_in),
    .latch(latch), .pulse(pulse), .busy(busy), .buttons(buttons), .valid(valid), .pressed(pressed)
  );

  n8_poll_scheduler #(
    .BITS(BITS), .NUM_PADS(NUM_PADS), .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS), .AUTO_PERIOD(200)
  ) dut_auto (
    .clk(clk), .reset(rst_auto), .poll_req(a_poll_req), .data_in(a_data),
    .latch(a_latch), .pulse(a_pulse), .busy(a_busy), .buttons(a_buttons), .valid(a_valid),
    .pressed(a_pressed)
  );

  // Pad model: latch parallel-loads, each pulse rising edge presents the next bit (MSB first).
  logic [7:0] pad_word [2];
  int         idx = 0;
  logic       pad_pulse_d = 1'b0;

  always @(posedge clk) begin
    pad_pulse_d <= pulse;
    if (latch) idx <= 0;
    else if (pulse && !pad_pulse_d && idx < 8) idx <= idx + 1;
  end

  always_comb begin
    data_in = '0;
    for (int p = 0; p < 2; p++) begin
      data_in[p] = (idx < 8) ? pad_word[p][7 - idx] : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] p;
    int           req;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] prev_model = '0;

  task automatic expect_poll(input logic [W-1:0] b, input int req);
    exp_t e;
    e.b = b;
`ifdef N8_PRESS_EDGE_EN
    e.p = b & ~prev_model;
`else
    e.p = '0;
`endif
    e.req = req;
    prev_model = b;
    sb.push_back(e);
  endtask

  // Monitor for the main instance
  int   latch_run = 0, latch_len = 0, pulse_run = 0, pulse_falls = 0, pulse_bad = 0, pulse_rises = 0;
  int   overlap_bad = 0, vwidth_bad = 0, valid_cnt = 0;
  logic latch_p = 1'b0, pulse_p = 1'b0, valid_p = 1'b0;
  int   latch_rise[$];

  always @(negedge clk) begin
    if (latch && pulse) overlap_bad++;
    if (a_latch && a_pulse) overlap_bad++;
    if (valid && valid_p) vwidth_bad++;
    if (latch && !latch_p) begin
      latch_rise.push_back(cyc);
      latch_run = 0; pulse_falls = 0; pulse_bad = 0; pulse_rises = 0;
    end
    if (latch) latch_run++;
    if (!latch && latch_p) latch_len = latch_run;
    if (pulse && !pulse_p) begin pulse_rises++; pulse_run = 0; end
    if (pulse) pulse_run++;
    if (!pulse && pulse_p) begin
      pulse_falls++;
      if (pulse_run != TICK_DIV) pulse_bad++;
    end
    if (valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_valid: got valid=1, expected no strobe (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("buttons", buttons, mon_e.b);
        check("pressed", pressed, mon_e.p);
        if (mon_e.req >= 0) check("valid_latency", cyc - mon_e.req, 69);
        check("latch_len", latch_len, 2 * TICK_DIV);
        check("sample_count", 1 + pulse_falls, BITS);
        check("pulse_width_errs", pulse_bad, 0);
      end
    end
    latch_p = latch; pulse_p = pulse; valid_p = valid;
  end

  // Monitor for the auto-poll instance: trigger cycles 199 + 200k, valid 69 later.
  int a_cnt = 0;
  int a_base = 0;

  always @(negedge clk) begin
    if (!rst_auto && a_valid && (cyc - a_base) <= 999 + 69) begin
      check("auto_valid_cycle", cyc - a_base, 268 + 200 * a_cnt);
      check("auto_buttons", a_buttons, 16'hFFFF);
      a_cnt++;
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_req();
    poll_req = 1'b1; step(1); poll_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    step(1);
    while (busy && k < budget) begin step(1); k++; end
    if (busy) begin
      tests++; fails++;
      $display("FAIL wait_idle_timeout: busy still 1 after %0d cycles, expected 0", budget);
    end
    step(2);
  endtask

  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[5];
  int   k, v0, nrise;

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 16'h3CA5};
    vecs[1] = '{8'h01, 8'h00, 16'h0001};
    vecs[2] = '{8'h03, 8'h00, 16'h0003};
    vecs[3] = '{8'h00, 8'hFF, 16'hFF00};
    vecs[4] = '{8'hFF, 8'h81, 16'h81FF};

    reset = 1'b1; rst_auto = 1'b1; poll_req = 1'b0;
    pad_word[0] = 8'h00; pad_word[1] = 8'h00;
    step(3);
    reset = 1'b0; rst_auto = 1'b0; a_base = cyc;

    check("rst_latch", latch, 0);
    check("rst_pulse", pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_buttons", buttons, 0);
    check("rst_pressed", pressed, 0);

    // Table-driven polls
    for (int i = 0; i < 5; i++) begin
      pad_word[0] = vecs[i].w0;
      pad_word[1] = vecs[i].w1;
      expect_poll(vecs[i].exp, cyc);
      pulse_req();
      wait_idle(200);
    end
    check("sb_drained", sb.size(), 0);

    // Reset during the 4th pulse: no commit, outputs cleared on the next edge.
    pad_word[0] = 8'h77; pad_word[1] = 8'h88;
    pulse_req();
    k = 0;
    while (!(pulse_rises == 4 && pulse) && k < 200) begin step(1); k++; end
    if (k >= 200) begin
      tests++; fails++;
      $display("FAIL abort_wait_timeout: 4th pulse not seen, expected within 200 cycles");
    end
    v0 = valid_cnt;
    reset = 1'b1;
    step(1);
    check("abort_latch", latch, 0);
    check("abort_pulse", pulse, 0);
    check("abort_busy", busy, 0);
    check("abort_buttons", buttons, 0);
    reset = 1'b0;
    prev_model = '0;
    step(120);
    check("abort_no_valid", valid_cnt - v0, 0);

    // Three requests during one poll: exactly one follow-on poll, right after GAP.
    pad_word[0] = 8'h5A; pad_word[1] = 8'hC3;
    v0 = valid_cnt;
    nrise = latch_rise.size();
    expect_poll(16'hC35A, cyc);
    expect_poll(16'hC35A, -1);
    pulse_req();
    step(10); pulse_req();
    step(20); pulse_req();
    step(20); pulse_req();
    k = 0;
    while (valid_cnt < v0 + 2 && k < 400) begin step(1); k++; end
    wait_idle(200);
    step(150);
    check("pending_valid_count", valid_cnt - v0, 2);
    if (latch_rise.size() >= nrise + 2) begin
      check("pending_restart_gap", latch_rise[nrise + 1] - latch_rise[nrise], 78);
    end else begin
      tests++; fails++;
      $display("FAIL pending_restart_gap: got %0d latch rises, expected 2", latch_rise.size() - nrise);
    end
    check("pending_sb_drained", sb.size(), 0);

    // Let the auto-poll instance complete its first 1000-cycle window.
    while (cyc < a_base + 999 + 69 + 5) step(1);
    check("auto_valid_count", a_cnt, 5);

    check("latch_pulse_overlap", overlap_bad, 0);
    check("valid_width", vwidth_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
